// File: rtl/posit_mul_sequencer_if.sv
// Host-side request/result handshake for the posit multiply sequencer.
// master = host, slave = sequencer.
interface posit_mul_sequencer_if;
  logic req_valid;
  logic req_ready;
  logic result_valid;
  logic result_ack;
  logic err_clear;

  modport master (
    output req_valid,
    output result_ack,
    output err_clear,
    input  req_ready,
    input  result_valid
  );

  modport slave (
    input  req_valid,
    input  result_ack,
    input  err_clear,
    output req_ready,
    output result_valid
  );
endinterface

// File: rtl/posit_mul_sequencer.sv
// Steps decode -> multiply -> adjust -> encode via start/done/recieved, at least 3 cycles per stage.
// One op in flight; req_ready only in IDLE, result held until result_ack, stalled stages time out to ERR.
module posit_mul_sequencer #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8,
  parameter int OPCNT_W        = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  posit_mul_sequencer_if.slave host,
  output logic               dec_start,
  output logic               mul_start,
  output logic               adj_start,
  output logic               enc_start,
  input  logic               dec_done,
  input  logic               mul_done,
  input  logic               adj_done,
  input  logic               enc_done,
  output logic               dec_recieved,
  output logic               mul_recieved,
  output logic               adj_recieved,
  output logic               enc_recieved,
  output logic               busy,
  output logic [1:0]         stage_id,
  output logic               err_timeout,
  output logic [OPCNT_W-1:0] op_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_ACK,
    S_OUT,
    S_ERR
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t             state_q, state_d;
  logic [1:0]         stage_q, stage_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [OPCNT_W-1:0] opcnt_q, opcnt_d;
  logic [3:0]         start_q, start_d;
  logic [3:0]         rcv_q, rcv_d;
  logic               req_ready_q;
  logic               busy_q;
  logic               result_valid_q;
  logic               err_q;
  logic [1:0]         stage_id_q;

  logic [3:0] done_vec;
  logic       done_sel;
  logic       timeout_hit;

  assign done_vec    = {enc_done, adj_done, mul_done, dec_done};
  assign done_sel    = done_vec[stage_q];
  assign timeout_hit = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    cnt_d   = cnt_q;
    opcnt_d = opcnt_q;

    case (state_q)
      S_IDLE: begin
        stage_d = 2'd0;
        if (host.req_valid) begin
          state_d = S_START;
        end
      end

      S_START: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end

      // done beats a simultaneous timeout
      S_WAIT: begin
        if (done_sel) begin
          cnt_d   = '0;
          state_d = S_ACK;
        end else if (timeout_hit) begin
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // recieved stays up until the stage actually drops done
      S_ACK: begin
        if (!done_sel) begin
          cnt_d = '0;
          if (stage_q == 2'd3) begin
            state_d = S_OUT;
          end else begin
            stage_d = stage_q + 2'd1;
            state_d = S_START;
          end
        end else if (timeout_hit) begin
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_OUT: begin
        if (host.result_ack) begin
          opcnt_d = opcnt_q + OPCNT_W'(1);
          stage_d = 2'd0;
          state_d = S_IDLE;
        end
      end

      S_ERR: begin
        if (host.err_clear) begin
          stage_d = 2'd0;
          state_d = S_IDLE;
        end
      end

      default: begin
        stage_d = 2'd0;
        state_d = S_IDLE;
      end
    endcase

    start_d = (state_d == S_START) ? (4'b0001 << stage_d) : 4'b0000;
    rcv_d   = (state_d == S_ACK)   ? (4'b0001 << stage_d) : 4'b0000;
  end

  // outputs are flopped from next-state so they line up with the state they describe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      stage_q        <= 2'd0;
      cnt_q          <= '0;
      opcnt_q        <= '0;
      start_q        <= 4'b0000;
      rcv_q          <= 4'b0000;
      req_ready_q    <= 1'b1;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      err_q          <= 1'b0;
      stage_id_q     <= 2'd0;
    end else begin
      state_q        <= state_d;
      stage_q        <= stage_d;
      cnt_q          <= cnt_d;
      opcnt_q        <= opcnt_d;
      start_q        <= start_d;
      rcv_q          <= rcv_d;
      req_ready_q    <= (state_d == S_IDLE);
      busy_q         <= (state_d != S_IDLE);
      result_valid_q <= (state_d == S_OUT);
      err_q          <= (state_d == S_ERR);
      stage_id_q     <= stage_d;
    end
  end

  assign host.req_ready    = req_ready_q;
  assign host.result_valid = result_valid_q;

  assign dec_start    = start_q[0];
  assign mul_start    = start_q[1];
  assign adj_start    = start_q[2];
  assign enc_start    = start_q[3];
  assign dec_recieved = rcv_q[0];
  assign mul_recieved = rcv_q[1];
  assign adj_recieved = rcv_q[2];
  assign enc_recieved = rcv_q[3];

  assign busy        = busy_q;
  assign stage_id    = stage_id_q;
  assign err_timeout = err_q;
  assign op_count    = opcnt_q;

endmodule

// File: tb/tb_posit_mul_sequencer.sv
// Directed bench for posit_mul_sequencer: stub stages with configurable done timing.
module tb_posit_mul_sequencer;

  localparam int TO  = 4;
  localparam int OPW = 4;

  logic clk;
  logic rst_n;

  posit_mul_sequencer_if host();

  logic dec_start, mul_start, adj_start, enc_start;
  logic dec_recieved, mul_recieved, adj_recieved, enc_recieved;
  logic busy, err_timeout;
  logic [1:0] stage_id;
  logic [OPW-1:0] op_count;
  logic [3:0] sdone;

  posit_mul_sequencer #(
    .TIMEOUT_CYCLES(TO),
    .CNT_W(8),
    .OPCNT_W(OPW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .host(host),
    .dec_start(dec_start),
    .mul_start(mul_start),
    .adj_start(adj_start),
    .enc_start(enc_start),
    .dec_done(sdone[0]),
    .mul_done(sdone[1]),
    .adj_done(sdone[2]),
    .enc_done(sdone[3]),
    .dec_recieved(dec_recieved),
    .mul_recieved(mul_recieved),
    .adj_recieved(adj_recieved),
    .enc_recieved(enc_recieved),
    .busy(busy),
    .stage_id(stage_id),
    .err_timeout(err_timeout),
    .op_count(op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [3:0] st_v = {enc_start, adj_start, mul_start, dec_start};
  wire [3:0] rc_v = {enc_recieved, adj_recieved, mul_recieved, dec_recieved};

  // stage stubs: done rises dly cycles after start is seen, falls linger cycles after recieved
  int dly[4];
  int linger[4];
  bit never[4];
  int phase[4];
  int scnt[4];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < 4; s++) begin
        phase[s] <= 0;
        scnt[s]  <= 0;
        sdone[s] <= 1'b0;
      end
    end else begin
      for (int s = 0; s < 4; s++) begin
        case (phase[s])
          0: if (st_v[s] && !never[s]) begin
               phase[s] <= 1;
               scnt[s]  <= dly[s] - 1;
             end
          1: if (scnt[s] == 0) begin
               sdone[s] <= 1'b1;
               phase[s] <= 2;
             end else begin
               scnt[s] <= scnt[s] - 1;
             end
          2: if (rc_v[s]) begin
               if (linger[s] == 0) begin
                 sdone[s] <= 1'b0;
                 phase[s] <= 0;
               end else begin
                 phase[s] <= 3;
                 scnt[s]  <= linger[s] - 1;
               end
             end
          3: if (scnt[s] == 0) begin
               sdone[s] <= 1'b0;
               phase[s] <= 0;
             end else begin
               scnt[s] <= scnt[s] - 1;
             end
          default: phase[s] <= 0;
        endcase
      end
    end
  end

  // strobe monitor, samples the cycle that ends at each rising edge
  int start_hi[4];
  int rcv_hi[4];
  int log_arr[512];
  int log_n;
  int multi_viol;
  int err_hi;

  initial begin
    for (int s = 0; s < 4; s++) begin
      start_hi[s] = 0;
      rcv_hi[s]   = 0;
    end
    log_n      = 0;
    multi_viol = 0;
    err_hi     = 0;
    forever begin
      @(posedge clk);
      for (int s = 0; s < 4; s++) begin
        if (st_v[s]) begin
          start_hi[s]++;
          if (log_n < 512) log_arr[log_n] = s;
          log_n++;
        end
        if (rc_v[s]) rcv_hi[s]++;
      end
      if ($countones({st_v, rc_v}) > 1) multi_viol++;
      if (err_timeout) err_hi++;
    end
  end

  int checks;
  int errors;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_req();
    @(negedge clk);
    host.req_valid = 1'b1;
    @(negedge clk);
    host.req_valid = 1'b0;
  endtask

  // cyc = number of negedges since the accepting edge
  task automatic wait_rv(output int cyc);
    cyc = 1;
    while (!host.result_valid && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic do_ack();
    host.result_ack = 1'b1;
    @(negedge clk);
    host.result_ack = 1'b0;
  endtask

  task automatic run_op(input string tag);
    int c;
    send_req();
    wait_rv(c);
    check(tag, host.result_valid, 1'b1);
    do_ack();
  endtask

  task automatic set_nominal();
    for (int s = 0; s < 4; s++) begin
      dly[s]    = 1;
      linger[s] = 0;
      never[s]  = 1'b0;
    end
  endtask

  initial begin
    int c;
    int n0;
    int r0[4];
    int s0[4];
    int e0;
    int hold;

    checks = 0;
    errors = 0;
    set_nominal();
    host.req_valid  = 1'b0;
    host.result_ack = 1'b0;
    host.err_clear  = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);

    check("rst_req_ready", host.req_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_result_valid", host.result_valid, 1'b0);
    check("rst_err", err_timeout, 1'b0);
    check("rst_stage_id", stage_id, 2'd0);
    check("rst_op_count", op_count, 0);
    check("rst_strobes", {st_v, rc_v}, 8'h00);
    rst_n = 1'b1;

    // nominal: done visible 2 edges after WAIT entry, 5 cycles per stage
    n0 = log_n;
    for (int s = 0; s < 4; s++) r0[s] = rcv_hi[s];
    send_req();
    check("nom_dec_start", dec_start, 1'b1);
    check("nom_busy", busy, 1'b1);
    check("nom_req_ready", host.req_ready, 1'b0);
    wait_rv(c);
    check("nom_latency", c, 21);
    check("nom_start_count", log_n - n0, 4);
    for (int s = 0; s < 4; s++) check("nom_start_order", log_arr[n0 + s], s);
    check("nom_dec_rcv_len", rcv_hi[0] - r0[0], 2);
    check("nom_enc_rcv_len", rcv_hi[3] - r0[3], 2);
    do_ack();
    check("nom_op_count", op_count, 1);
    check("nom_req_ready_after", host.req_ready, 1'b1);
    check("nom_rv_after", host.result_valid, 1'b0);

    // lingering done on adj: recieved stretches by one cycle, no repeat start
    linger[2] = 1;
    n0 = log_n;
    for (int s = 0; s < 4; s++) begin
      r0[s] = rcv_hi[s];
      s0[s] = start_hi[s];
    end
    send_req();
    wait_rv(c);
    check("lng_latency", c, 22);
    check("lng_adj_rcv_len", rcv_hi[2] - r0[2], 3);
    check("lng_adj_starts", start_hi[2] - s0[2], 1);
    check("lng_enc_starts", start_hi[3] - s0[3], 1);
    check("lng_start_count", log_n - n0, 4);
    do_ack();
    check("lng_op_count", op_count, 2);
    set_nominal();

    // race: mul done becomes visible on the counter's last WAIT cycle
    dly[1] = 3;
    e0 = err_hi;
    send_req();
    wait_rv(c);
    check("race_latency", c, 23);
    check("race_no_err", err_hi - e0, 0);
    do_ack();
    check("race_op_count", op_count, 3);
    set_nominal();

    // timeout: mul never answers, ERR TO cycles after WAIT entry
    never[1] = 1'b1;
    send_req();
    c = 1;
    while (!err_timeout && c < 400) begin
      @(negedge clk);
      c++;
    end
    check("to_latency", c, 11);
    check("to_stage_id", stage_id, 2'd1);
    check("to_err", err_timeout, 1'b1);
    check("to_strobes", {st_v, rc_v}, 8'h00);
    check("to_rv", host.result_valid, 1'b0);
    host.result_ack = 1'b1;
    repeat (3) @(negedge clk);
    host.result_ack = 1'b0;
    check("to_err_held", {err_timeout, stage_id}, 3'b101);
    host.err_clear = 1'b1;
    @(negedge clk);
    host.err_clear = 1'b0;
    check("to_clear_ready", host.req_ready, 1'b1);
    check("to_clear_err", err_timeout, 1'b0);
    check("to_clear_stage", stage_id, 2'd0);
    check("to_op_count", op_count, 3);
    set_nominal();

    // async reset while adj is in WAIT
    dly[2] = 6;
    send_req();
    c = 0;
    while (!adj_start && c < 400) begin
      @(negedge clk);
      c++;
    end
    check("rm_adj_reached", adj_start, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rm_busy", busy, 1'b0);
    check("rm_req_ready", host.req_ready, 1'b1);
    check("rm_stage_id", stage_id, 2'd0);
    check("rm_op_count", op_count, 0);
    check("rm_strobes", {st_v, rc_v}, 8'h00);
    n0 = log_n;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    set_nominal();
    repeat (2) @(negedge clk);
    check("rm_no_strobe", log_n - n0, 0);
    send_req();
    wait_rv(c);
    check("rm_restart_dec", log_arr[n0], 0);
    check("rm_restart_count", log_n - n0, 4);
    do_ack();
    check("rm_op_count_after", op_count, 1);

    // back-pressure: result held, request ignored until back in IDLE
    n0 = log_n;
    send_req();
    wait_rv(c);
    host.req_valid = 1'b1;
    hold = 0;
    repeat (10) begin
      @(negedge clk);
      if (host.result_valid && !host.req_ready) hold++;
    end
    check("bp_hold", hold, 10);
    check("bp_no_new_start", log_n - n0, 4);
    do_ack();
    check("bp_idle_ready", host.req_ready, 1'b1);
    check("bp_idle_no_start", dec_start, 1'b0);
    check("bp_op_count", op_count, 2);
    @(negedge clk);
    host.req_valid = 1'b0;
    check("bp_accept_next", dec_start, 1'b1);
    wait_rv(c);
    check("bp_second_rv", host.result_valid, 1'b1);
    do_ack();
    check("bp_op_count2", op_count, 3);

    // op counter wrap
    for (int i = 0; i < 12; i++) run_op("wrap_op");
    check("wrap_pre", op_count, 15);
    run_op("wrap_last");
    check("wrap_zero", op_count, 0);

    check("one_hot_strobes", multi_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
